// File: rtl/mdu_exec_pkg.sv
// Shared MDU definitions: operation codes, FSM state encoding and default latencies.
// Used by the decoder, the hazard unit and the execute-stage multiply/divide unit.
package mdu_defs;

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4
  } mdu_op_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } mdu_state_t;

  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;

  function automatic logic op_is_valid(input logic [3:0] op);
    return (op >= 4'(OP_MULT)) && (op <= 4'(OP_DIVU));
  endfunction

  function automatic logic op_is_div(input logic [3:0] op);
    return (op == 4'(OP_DIV)) || (op == 4'(OP_DIVU));
  endfunction

endpackage

// File: rtl/mdu_exec_arith.sv
// Combinational multiply/divide datapath: produces the full HI/LO result for one op.
// Signed division works on magnitudes so the 0x80000000 / -1 case needs no special path.
module mdu_arith
  import mdu_defs::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        div_by_zero
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] b_safe;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] q_u;
  logic [31:0] r_u;

  // Lower 64 bits of a sign-extended product equal the signed 32x32 product.
  assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign prod_u = {32'd0, a} * {32'd0, b};

  // A zero divisor is replaced so the dividers never see it; the result is discarded anyway.
  assign b_safe = (b == 32'd0) ? 32'd1 : b;
  assign mag_a  = a[31] ? (32'd0 - a) : a;
  assign mag_b  = b_safe[31] ? (32'd0 - b_safe) : b_safe;
  assign q_mag  = mag_a / mag_b;
  assign r_mag  = mag_a % mag_b;
  assign q_u    = a / b_safe;
  assign r_u    = a % b_safe;

  always_comb begin
    res_hi      = 32'd0;
    res_lo      = 32'd0;
    div_by_zero = 1'b0;
    case (op)
      4'(OP_MULT): begin
        res_hi = prod_s[63:32];
        res_lo = prod_s[31:0];
      end
      4'(OP_MULTU): begin
        res_hi = prod_u[63:32];
        res_lo = prod_u[31:0];
      end
      4'(OP_DIV): begin
        res_lo      = (a[31] ^ b[31]) ? (32'd0 - q_mag) : q_mag;
        res_hi      = a[31] ? (32'd0 - r_mag) : r_mag;
        div_by_zero = (b == 32'd0);
      end
      4'(OP_DIVU): begin
        res_lo      = q_u;
        res_hi      = r_u;
        div_by_zero = (b == 32'd0);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_exec.sv
// Execute-stage multiply/divide unit: owns HI/LO, holds a computed result for a fixed
// busy window, then commits HI and LO together; serves mfhi/mflo and mthi/mtlo.
module mdu_exec
  import mdu_defs::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  mdu_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        hi_write,
  input  logic        lo_write,
  input  logic        hi_read,
  input  logic        lo_read,
  output logic        busy,
  output logic [31:0] rdata,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  mdu_state_t       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [31:0]      pend_hi_reg, pend_hi_next;
  logic [31:0]      pend_lo_reg, pend_lo_next;
  logic             pend_skip_reg, pend_skip_next;
  logic [31:0]      hi_reg, hi_next;
  logic [31:0]      lo_reg, lo_next;

  logic [31:0] res_hi;
  logic [31:0] res_lo;
  logic        div_by_zero;

  mdu_arith u_arith (
    .op          (mdu_op),
    .a           (src_a),
    .b           (src_b),
    .res_hi      (res_hi),
    .res_lo      (res_lo),
    .div_by_zero (div_by_zero)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg     <= S_IDLE;
      cnt_reg       <= '0;
      pend_hi_reg   <= 32'd0;
      pend_lo_reg   <= 32'd0;
      pend_skip_reg <= 1'b0;
      hi_reg        <= 32'd0;
      lo_reg        <= 32'd0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      pend_hi_reg   <= pend_hi_next;
      pend_lo_reg   <= pend_lo_next;
      pend_skip_reg <= pend_skip_next;
      hi_reg        <= hi_next;
      lo_reg        <= lo_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    pend_hi_next   = pend_hi_reg;
    pend_lo_next   = pend_lo_reg;
    pend_skip_next = pend_skip_reg;
    hi_next        = hi_reg;
    lo_next        = lo_reg;
    case (state_reg)
      S_IDLE: begin
        // start takes priority over mthi/mtlo even when the op code is not a real op.
        if (start) begin
          if (op_is_valid(mdu_op)) begin
            pend_hi_next   = res_hi;
            pend_lo_next   = res_lo;
            pend_skip_next = div_by_zero;
            cnt_next       = op_is_div(mdu_op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            state_next     = S_BUSY;
          end
        end else begin
          if (hi_write) hi_next = src_a;
          if (lo_write) lo_next = src_a;
        end
      end
      S_BUSY: begin
        if (cnt_reg == CNT_W'(1)) begin
          if (!pend_skip_reg) begin
            hi_next = pend_hi_reg;
            lo_next = pend_lo_reg;
          end
          cnt_next   = '0;
          state_next = S_IDLE;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign busy  = (state_reg == S_BUSY);
  assign hi    = hi_reg;
  assign lo    = lo_reg;
  assign rdata = hi_read ? hi_reg : (lo_read ? lo_reg : 32'd0);

endmodule

// File: tb/tb_mdu_exec.sv
// Self-checking bench for mdu_exec: directed vector table, hand sequences for
// reset/back-pressure corners, and random ops against a 64-bit arithmetic model.
module tb_mdu_exec;
  import mdu_defs::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  mdu_op = 4'd0;
  logic [31:0] src_a = 32'd0;
  logic [31:0] src_b = 32'd0;
  logic        hi_write = 1'b0;
  logic        lo_write = 1'b0;
  logic        hi_read = 1'b0;
  logic        lo_read = 1'b0;
  logic        busy;
  logic [31:0] rdata;
  logic [31:0] hi;
  logic [31:0] lo;

  int total = 0;
  int bad = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          exp_cyc;
  } vec_t;

  vec_t vecs[7];

  mdu_exec #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .mdu_op   (mdu_op),
    .src_a    (src_a),
    .src_b    (src_b),
    .hi_write (hi_write),
    .lo_write (lo_write),
    .hi_read  (hi_read),
    .lo_read  (lo_read),
    .busy     (busy),
    .rdata    (rdata),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Architectural result of one op, from plain 64-bit arithmetic.
  function automatic void ref_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                    input logic [31:0] hi_in, input logic [31:0] lo_in,
                                    output logic [31:0] hi_out, output logic [31:0] lo_out);
    longint sa, sb, q, r;
    logic [63:0] p;
    hi_out = hi_in;
    lo_out = lo_in;
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      4'd1: begin p = 64'(sa * sb); hi_out = p[63:32]; lo_out = p[31:0]; end
      4'd2: begin p = 64'(a) * 64'(b); hi_out = p[63:32]; lo_out = p[31:0]; end
      4'd3: if (b != 0) begin
        q = sa / sb; r = sa % sb;
        lo_out = q[31:0]; hi_out = r[31:0];
      end
      4'd4: if (b != 0) begin lo_out = a / b; hi_out = a % b; end
      default: ;
    endcase
  endfunction

  // Issues one op in the current cycle and counts busy cycles; inject pokes start/mthi/mtlo mid-op.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit inject, output int cyc);
    mdu_op = op; src_a = a; src_b = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; mdu_op = 4'd0;
    cyc = 0;
    while (busy && cyc < 64) begin
      cyc++;
      if (inject && cyc == 2) begin
        check("busy_hold_hi", hi, m_hi);
        start = 1'b1; mdu_op = 4'(OP_DIV); src_a = 32'hDEAD0000; src_b = 32'd3;
        hi_write = 1'b1; lo_write = 1'b1;
      end
      @(posedge clk); #1;
      start = 1'b0; mdu_op = 4'd0; hi_write = 1'b0; lo_write = 1'b0;
    end
  endtask

  task automatic mt(input bit hw, input bit lw, input logic [31:0] val);
    hi_write = hw; lo_write = lw; src_a = val;
    @(posedge clk); #1;
    hi_write = 1'b0; lo_write = 1'b0;
    if (hw) m_hi = val;
    if (lw) m_lo = val;
  endtask

  task automatic do_checked_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                               input logic [31:0] b, input bit inject);
    int cyc;
    int exp_cyc;
    logic [31:0] eh, el;
    ref_model(op, a, b, m_hi, m_lo, eh, el);
    exp_cyc = (op == 4'd1 || op == 4'd2) ? 5 : (op == 4'd3 || op == 4'd4) ? 10 : 0;
    run_op(op, a, b, inject, cyc);
    m_hi = eh; m_lo = el;
    check({tag, "_cycles"}, 32'(cyc), 32'(exp_cyc));
    check({tag, "_hi"}, hi, m_hi);
    check({tag, "_lo"}, lo, m_lo);
    $display("%s op=%0d a=%h b=%h -> hi=%h lo=%h busy_cycles=%0d", tag, op, a, b, hi, lo, cyc);
  endtask

  initial begin
    int cyc;
    vecs[0] = '{4'd1, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 5};
    vecs[1] = '{4'd2, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, 5};
    vecs[2] = '{4'd3, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[3] = '{4'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
    vecs[4] = '{4'd4, 32'd100,      32'd7,        32'h00000002, 32'h0000000E, 10};
    vecs[5] = '{4'd3, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
    vecs[6] = '{4'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    hi_read = 1'b1; #1;
    check("rst_rdata", rdata, 32'd0);
    hi_read = 1'b0;
    reset = 1'b1;

    // Directed table, issued back-to-back
    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, cyc);
      check($sformatf("vec%0d_cycles", i), 32'(cyc), 32'(vecs[i].exp_cyc));
      check($sformatf("vec%0d_hi", i), hi, vecs[i].exp_hi);
      check($sformatf("vec%0d_lo", i), lo, vecs[i].exp_lo);
      $display("vec%0d op=%0d a=%h b=%h -> hi=%h lo=%h busy_cycles=%0d",
               i, vecs[i].op, vecs[i].a, vecs[i].b, hi, lo, cyc);
      m_hi = vecs[i].exp_hi; m_lo = vecs[i].exp_lo;
    end

    // mthi / mtlo and read mux
    mt(1'b1, 1'b0, 32'h00001234);
    mt(1'b0, 1'b1, 32'h00005678);
    hi_read = 1'b1; lo_read = 1'b0; #1; check("mfhi", rdata, 32'h00001234);
    hi_read = 1'b0; lo_read = 1'b1; #1; check("mflo", rdata, 32'h00005678);
    hi_read = 1'b1; lo_read = 1'b1; #1; check("both_read", rdata, 32'h00001234);
    hi_read = 1'b0; lo_read = 1'b0; #1; check("no_read", rdata, 32'd0);
    mt(1'b1, 1'b1, 32'h0000BEEF);
    check("mt_both_hi", hi, 32'h0000BEEF);
    check("mt_both_lo", lo, 32'h0000BEEF);
    $display("mthi/mtlo hi=%h lo=%h", hi, lo);

    // start (even with OP_NONE) suppresses mthi
    start = 1'b1; mdu_op = 4'd0; hi_write = 1'b1; src_a = 32'hCAFE0000;
    @(posedge clk); #1;
    start = 1'b0; hi_write = 1'b0;
    check("start_beats_mthi", hi, m_hi);
    check("op_none_busy", 32'(busy), 32'd0);

    // Divide by zero: full window, HI/LO untouched
    do_checked_op("divu_zero", 4'd4, 32'd5, 32'd0, 1'b0);
    do_checked_op("div_zero", 4'd3, 32'hFFFFFF00, 32'd0, 1'b0);

    // start + mthi/mtlo during BUSY ignored, original mult commits on schedule
    do_checked_op("inject", 4'd1, 32'hFFFFFFFE, 32'd3, 1'b1);

    // Reset mid-operation
    mt(1'b1, 1'b1, 32'h0000AAAA);
    mdu_op = 4'd1; src_a = 32'd6; src_b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; mdu_op = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    check("pre_rst_busy", 32'(busy), 32'd1);
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    m_hi = 32'd0; m_lo = 32'd0;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_hi", hi, 32'd0);
    check("midrst_lo", lo, 32'd0);
    repeat (8) @(posedge clk);
    #1;
    check("midrst_nocommit_hi", hi, 32'd0);
    check("midrst_nocommit_lo", lo, 32'd0);
    $display("midop reset hi=%h lo=%h busy=%0d", hi, lo, busy);

    // Random ops against the reference model
    for (int i = 0; i < 24; i++) begin
      logic [3:0]  op;
      logic [31:0] a, b;
      op = 4'($urandom_range(1, 4));
      a = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 9));
        2: b = 32'hFFFFFFFF;
        default: b = $urandom;
      endcase
      do_checked_op($sformatf("rnd%0d", i), op, a, b, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
